dram_req_buffer: RTL and testbench

Per-bank L2 request FIFO in front of the DRAM controller's address translation stage. One instance is placed per L2 request port. Each instance captures address, read/write flag and write data under a valid/ready handshake and holds them in arrival order. It presents the oldest entry first-word-fall-through to the downstream translator/scheduler, with occupancy and almost-full status for back-pressure.

---
 rtl/dram_req_buffer.sv | 89 ++++++++
 tb/tb_dram_req_buffer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dram_req_buffer.sv
// Per-port L2 request FIFO feeding the DRAM address translator.
// First-word-fall-through head, registered occupancy and almost-full status.
module dram_req_buffer #(
   parameter int unsigned ADDR_WIDTH = 13,
   parameter int unsigned DATA_WIDTH = 1,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned AF_THRESH  = 6
) (
   input  logic                         clk,
   input  logic                         rst_b,
   input  logic                         flush,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [ADDR_WIDTH-1:0]        req_addr,
   input  logic                         req_rw,
   input  logic [DATA_WIDTH-1:0]        req_wdata,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ADDR_WIDTH-1:0]        out_addr,
   output logic                         out_rw,
   output logic [DATA_WIDTH-1:0]        out_wdata,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         almost_full
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam logic [CntW-1:0] FullLevel = CntW'(DEPTH);
   localparam logic [CntW-1:0] AfLevel   = CntW'(AF_THRESH);

   logic [ADDR_WIDTH-1:0] mem_addr  [DEPTH];
   logic                  mem_rw    [DEPTH];
   logic [DATA_WIDTH-1:0] mem_wdata [DEPTH];

   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic            af_q;
   logic            push, pop;

   // Ready looks only at registered count: a pop never frees room for a same-cycle push.
   assign req_ready = (count_q != FullLevel);
   assign out_valid = (count_q != '0);
   assign push      = req_valid & req_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         af_q     <= 1'b0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         af_q     <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_d;
         af_q    <= (count_d >= AfLevel);
      end
   end

   // Storage is deliberately unreset; empty-state output gating hides stale entries.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_addr[wr_ptr_q]  <= req_addr;
         mem_rw[wr_ptr_q]    <= req_rw;
         mem_wdata[wr_ptr_q] <= req_wdata;
      end
   end

   assign out_addr    = out_valid ? mem_addr[rd_ptr_q]  : '0;
   assign out_rw      = out_valid ? mem_rw[rd_ptr_q]    : 1'b0;
   assign out_wdata   = out_valid ? mem_wdata[rd_ptr_q] : '0;
   assign count       = count_q;
   assign almost_full = af_q;

endmodule

// File: tb/tb_dram_req_buffer.sv
// Bench for dram_req_buffer: queue-based reference model checked every cycle,
// plus a vector table and hand sequences for full, simultaneous, flush and reset cases.
module tb_dram_req_buffer;

   localparam int AW    = 13;
   localparam int DEPTH = 8;
   localparam int AF    = 6;

   logic          clk = 1'b0;
   logic          rst_b;
   logic          flush;
   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_addr;
   logic          req_rw;
   logic [0:0]    req_wdata;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_addr;
   logic          out_rw;
   logic [0:0]    out_wdata;
   logic [3:0]    count;
   logic          almost_full;

   dram_req_buffer #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (1),
      .DEPTH      (DEPTH),
      .AF_THRESH  (AF)
   ) dut (
      .clk         (clk),
      .rst_b       (rst_b),
      .flush       (flush),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_rw      (req_rw),
      .req_wdata   (req_wdata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_addr    (out_addr),
      .out_rw      (out_rw),
      .out_wdata   (out_wdata),
      .count       (count),
      .almost_full (almost_full)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic          rw;
      logic          wd;
   } ent_t;

   typedef struct {
      logic          rv;
      logic [AW-1:0] addr;
      logic          rw;
      logic          wd;
      logic          ordy;
      int            exp_count;
      logic          exp_ready;
      logic          exp_valid;
      logic          exp_af;
   } vec_t;

   ent_t m_q[$];
   vec_t vecs[10];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare DUT against the model just before the edge, then advance the model.
   task automatic step(input logic rv, input logic [AW-1:0] a, input logic rw, input logic wd,
                       input logic ordy, input logic fl);
      logic do_push, do_pop;
      ent_t e;
      req_valid = rv;
      req_addr  = a;
      req_rw    = rw;
      req_wdata = wd;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      chk("count", 32'(count), 32'(m_q.size()));
      chk("req_ready", 32'(req_ready), 32'(m_q.size() != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      chk("almost_full", 32'(almost_full), 32'(m_q.size() >= AF));
      if (m_q.size() != 0) begin
         chk("head_addr", 32'(out_addr), 32'(m_q[0].addr));
         chk("head_rw", 32'(out_rw), 32'(m_q[0].rw));
         chk("head_wdata", 32'(out_wdata), 32'(m_q[0].wd));
      end else begin
         chk("empty_addr", 32'(out_addr), 32'h0);
         chk("empty_rw", 32'(out_rw), 32'h0);
         chk("empty_wdata", 32'(out_wdata), 32'h0);
      end
      do_push = rv && (m_q.size() != DEPTH);
      do_pop  = ordy && (m_q.size() != 0);
      if (fl) begin
         m_q.delete();
      end else begin
         if (do_pop) void'(m_q.pop_front());
         if (do_push) begin
            e.addr = a;
            e.rw   = rw;
            e.wd   = wd;
            m_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_step(input logic ordy);
      step(1'b0, '0, 1'b0, 1'b0, ordy, 1'b0);
   endtask

   initial begin
      int i;
      // Full-buffer table: 8 pushes with no pops, then a rejected push during a pop, then accept.
      for (int k = 0; k < DEPTH; k++) begin
         vecs[k] = '{rv: 1'b1, addr: AW'(13'h100 + k), rw: k[0], wd: ~k[0], ordy: 1'b0,
                     exp_count: k + 1, exp_ready: (k + 1 != DEPTH), exp_valid: 1'b1,
                     exp_af: (k + 1 >= AF)};
      end
      vecs[8] = '{rv: 1'b1, addr: 13'h1ff, rw: 1'b1, wd: 1'b1, ordy: 1'b1,
                  exp_count: 7, exp_ready: 1'b1, exp_valid: 1'b1, exp_af: 1'b1};
      vecs[9] = '{rv: 1'b1, addr: 13'h1ff, rw: 1'b1, wd: 1'b1, ordy: 1'b0,
                  exp_count: 8, exp_ready: 1'b0, exp_valid: 1'b1, exp_af: 1'b1};

      rst_b = 1'b0;
      flush = 1'b0; req_valid = 1'b0; req_addr = '0; req_rw = 1'b0; req_wdata = '0;
      out_ready = 1'b0;
      #1;
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_ready", 32'(req_ready), 32'h1);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_af", 32'(almost_full), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_b = 1'b1;
      @(posedge clk);
      #1;

      for (int k = 0; k < 10; k++) begin
         step(vecs[k].rv, vecs[k].addr, vecs[k].rw, vecs[k].wd, vecs[k].ordy, 1'b0);
         chk("vec_count", 32'(count), 32'(vecs[k].exp_count));
         chk("vec_ready", 32'(req_ready), 32'(vecs[k].exp_ready));
         chk("vec_valid", 32'(out_valid), 32'(vecs[k].exp_valid));
         chk("vec_af", 32'(almost_full), 32'(vecs[k].exp_af));
      end
      repeat (DEPTH) idle_step(1'b1);
      chk("drained", 32'(count), 32'h0);

      // Simultaneous push and pop at count 3.
      for (int k = 0; k < 3; k++) step(1'b1, AW'(13'h20 + k), 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 13'h2a, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("simul_count", 32'(count), 32'h3);
      chk("simul_head", 32'(out_addr), 32'h21);
      repeat (3) idle_step(1'b1);
      chk("simul_empty", 32'(count), 32'h0);
      // Empty with request and out_ready: no pop, no bypass.
      step(1'b1, 13'h33, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("empty_push_count", 32'(count), 32'h1);
      chk("empty_push_head", 32'(out_addr), 32'h33);
      idle_step(1'b1);

      // Flush at count 5 with a push and pop pending.
      for (int k = 0; k < 5; k++) step(1'b1, AW'(13'h40 + k), 1'b1, 1'b1, 1'b0, 1'b0);
      chk("pre_flush", 32'(count), 32'h5);
      step(1'b1, 13'h55, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("flush_count", 32'(count), 32'h0);
      chk("flush_valid", 32'(out_valid), 32'h0);
      chk("flush_addr", 32'(out_addr), 32'h0);
      idle_step(1'b0);

      // 20 in-order requests with random pops; pointers wrap twice.
      i = 0;
      for (int cyc = 0; cyc < 400 && (i < 20 || m_q.size() != 0); cyc++) begin
         if (i < 20) begin
            if (m_q.size() != DEPTH) begin
               step(1'b1, AW'(i), i[0], i[0], 1'($urandom_range(0, 1)), 1'b0);
               i++;
            end else begin
               step(1'b1, AW'(i), i[0], i[0], 1'($urandom_range(0, 1)), 1'b0);
            end
         end else begin
            idle_step(1'($urandom_range(0, 1)));
         end
      end
      chk("order_done", 32'(m_q.size() == 0 && i == 20), 32'h1);
      chk("order_count", 32'(count), 32'h0);

      // Asynchronous reset mid-stream at count 3.
      for (int k = 0; k < 3; k++) step(1'b1, AW'(13'h60 + k), 1'b1, 1'b1, 1'b0, 1'b0);
      req_valid = 1'b0;
      #2;
      rst_b = 1'b0;
      #1;
      chk("arst_count", 32'(count), 32'h0);
      chk("arst_valid", 32'(out_valid), 32'h0);
      chk("arst_addr", 32'(out_addr), 32'h0);
      chk("arst_ready", 32'(req_ready), 32'h1);
      m_q.delete();
      @(negedge clk);
      rst_b = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 13'h0a5, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("post_rst_addr", 32'(out_addr), 32'h0a5);
      chk("post_rst_valid", 32'(out_valid), 32'h1);
      idle_step(1'b1);
      idle_step(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
